// File: rtl/cam_pkg.sv
// Shared constants and FSM state type for the camera capture path.
// The defaults describe an 80x60 RGB444 image taken from a 640x480 source.
package cam_pkg;

  localparam int c_nb_img_pxls = 13;
  localparam int c_nb_buf      = 12;
  localparam int c_img_cols    = 80;
  localparam int c_img_rows    = 60;
  localparam int c_sub_log2    = 3;

  localparam int c_src_cols = c_img_cols << c_sub_log2;
  localparam int c_src_rows = c_img_rows << c_sub_log2;
  localparam int c_img_pxls = c_img_cols * c_img_rows;

  typedef enum logic [2:0] {
    S_SYNC,
    S_VWAIT,
    S_FRAME,
    S_LINE,
    S_FRAME_END
  } state_t;

endpackage

// File: rtl/cam_byte_pair.sv
// Pairs RGB444 camera bytes into one 12-bit pixel with a single-cycle valid.
// Any href edge realigns the pairing so a stray odd byte never shifts later pixels.
module cam_byte_pair
  import cam_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                en,
  input  logic [7:0]          data,
  output logic [c_nb_buf-1:0] pix,
  output logic                valid
);

  logic       phase;
  logic [3:0] r_nib;

  // NOTE: non-blocking assignments so phase and the R latch both see the pre-edge phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 1'b0;
      r_nib <= '0;
    end else if (clear) begin
      phase <= 1'b0;
    end else if (en) begin
      phase <= ~phase;
      if (!phase) r_nib <= data[3:0];
    end
  end

  assign pix   = {r_nib, data};
  assign valid = en & phase & ~clear;

endmodule

// File: rtl/cam_capture_rgb444.sv
// Camera-side writer: subsamples an RGB444 byte stream and writes the kept
// pixels into the frame buffer in raster order, reporting each frame's end.
module cam_capture_rgb444 #(
  parameter int c_nb_img_pxls = cam_pkg::c_nb_img_pxls,
  parameter int c_nb_buf      = cam_pkg::c_nb_buf,
  parameter int c_img_cols    = cam_pkg::c_img_cols,
  parameter int c_img_rows    = cam_pkg::c_img_rows,
  parameter int c_sub_log2    = cam_pkg::c_sub_log2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cam_vsync,
  input  logic                     cam_href,
  input  logic                     cam_byte_en,
  input  logic [7:0]               cam_data,
  output logic                     wea,
  output logic [c_nb_img_pxls-1:0] addrin,
  output logic [c_nb_buf-1:0]      datain,
  output logic                     frame_done,
  output logic                     frame_short
);

  import cam_pkg::*;

  localparam int c_src_cols = c_img_cols << c_sub_log2;
  localparam int c_src_rows = c_img_rows << c_sub_log2;
  localparam int c_col_w    = $clog2(c_src_cols + 1);
  localparam int c_row_w    = $clog2(c_src_rows + 1);
  localparam int c_ocol_w   = $clog2(c_img_cols + 1);
  localparam int c_orow_w   = $clog2(c_img_rows + 1);

  localparam logic [c_ocol_w-1:0]    c_cols_lim = c_ocol_w'(c_img_cols);
  localparam logic [c_orow_w-1:0]    c_rows_lim = c_orow_w'(c_img_rows);
  localparam logic [c_nb_img_pxls:0] c_pxls_lim = (c_nb_img_pxls + 1)'(c_img_cols * c_img_rows);

  state_t               state;
  logic                 href_q;
  logic                 vsync_q;
  logic [c_col_w-1:0]   src_col;
  logic [c_row_w-1:0]   src_row;
  logic [c_ocol_w-1:0]  out_col;
  logic [c_orow_w-1:0]  out_row;
  logic                 row_wrote;

  logic                 href_rise;
  logic                 href_fall;
  logic                 vsync_rise;
  logic                 pix_valid;
  logic                 keep;
  logic [c_nb_buf-1:0]  pix;
  logic [c_nb_img_pxls:0] wr_total;

  assign href_rise  = cam_href & ~href_q;
  assign href_fall  = ~cam_href & href_q;
  assign vsync_rise = cam_vsync & ~vsync_q;

  cam_byte_pair u_pair (
    .clk   (clk),
    .rst   (rst),
    .clear (href_rise | href_fall),
    .en    (cam_byte_en & (state == S_LINE)),
    .data  (cam_data),
    .pix   (pix),
    .valid (pix_valid)
  );

  // Out-of-range guards on out_col/out_row are what stop the address from wrapping.
  assign keep = pix_valid
             && (src_col[c_sub_log2-1:0] == '0)
             && (src_row[c_sub_log2-1:0] == '0)
             && (out_col < c_cols_lim)
             && (out_row < c_rows_lim);

  // A write still in flight has not yet bumped addrin, so count it here.
  assign wr_total = {1'b0, addrin} + (c_nb_img_pxls + 1)'(wea);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_SYNC;
      href_q      <= 1'b0;
      vsync_q     <= 1'b0;
      src_col     <= '0;
      src_row     <= '0;
      out_col     <= '0;
      out_row     <= '0;
      row_wrote   <= 1'b0;
      wea         <= 1'b0;
      addrin      <= '0;
      datain      <= '0;
      frame_done  <= 1'b0;
      frame_short <= 1'b0;
    end else begin
      href_q     <= cam_href;
      vsync_q    <= cam_vsync;
      wea        <= 1'b0;
      frame_done <= 1'b0;
      if (wea) addrin <= addrin + 1'b1;

      if ((state == S_FRAME || state == S_LINE) && vsync_rise) begin
        state       <= S_FRAME_END;
        frame_done  <= 1'b1;
        frame_short <= (wr_total != c_pxls_lim);
      end else begin
        unique case (state)
          S_SYNC: if (cam_vsync) state <= S_VWAIT;
          S_VWAIT: begin
            if (!cam_vsync) begin
              state   <= S_FRAME;
              addrin  <= '0;
              src_row <= '0;
              out_row <= '0;
            end
          end
          S_FRAME: begin
            if (href_rise) begin
              state     <= S_LINE;
              src_col   <= '0;
              out_col   <= '0;
              row_wrote <= 1'b0;
            end
          end
          S_LINE: begin
            if (href_fall) begin
              state <= S_FRAME;
              if (src_row != '1) src_row <= src_row + 1'b1;
              if (row_wrote) out_row <= out_row + 1'b1;
            end else if (pix_valid) begin
              if (src_col != '1) src_col <= src_col + 1'b1;
              if (keep) begin
                wea       <= 1'b1;
                datain    <= pix;
                out_col   <= out_col + 1'b1;
                row_wrote <= 1'b1;
              end
            end
          end
          S_FRAME_END: state <= S_VWAIT;
          default:     state <= S_SYNC;
        endcase
      end
    end
  end

endmodule
